// File: rtl/clause_table_loader.sv
// Packs streamed clause slot words into wide clause-table rows and writes one
// row per cycle-long WRITE phase; flags rows that overrun without s_last_i.
module clause_table_loader #(
  parameter int CLAUSE_COUNT           = 20,
  parameter int VARIABLE_ADDRESS_WIDTH = 11,
  parameter int NSAT                   = 3,
  localparam int SLOT_WIDTH = (VARIABLE_ADDRESS_WIDTH + 1) * (NSAT - 1),
  localparam int CT_WIDTH   = SLOT_WIDTH * CLAUSE_COUNT
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              start_i,
  input  logic [VARIABLE_ADDRESS_WIDTH:0]   row_count_i,
  input  logic                              s_valid_i,
  output logic                              s_ready_o,
  input  logic [SLOT_WIDTH-1:0]             s_data_i,
  input  logic                              s_last_i,
  output logic                              axi_wr_en_o,
  output logic [VARIABLE_ADDRESS_WIDTH-1:0] axi_wr_addr_o,
  output logic [CT_WIDTH-1:0]               axi_wr_clauses_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o
);

  localparam int ROW_W      = VARIABLE_ADDRESS_WIDTH + 1;
  localparam int SLOT_IDX_W = (CLAUSE_COUNT > 1) ? $clog2(CLAUSE_COUNT) : 1;
  localparam logic [ROW_W-1:0]      MAX_ROWS  = {1'b1, {VARIABLE_ADDRESS_WIDTH{1'b0}}};
  localparam logic [SLOT_IDX_W-1:0] LAST_SLOT = SLOT_IDX_W'(CLAUSE_COUNT - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_e;

  state_e                            state_q, state_d;
  logic [ROW_W-1:0]                  n_q, n_d;
  logic [ROW_W-1:0]                  row_q, row_d;
  logic [SLOT_IDX_W-1:0]             slot_q, slot_d;
  logic [CT_WIDTH-1:0]               acc_q, acc_d;
  logic                              err_q, err_d;
  logic                              wr_en_q, wr_en_d;
  logic [VARIABLE_ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [CT_WIDTH-1:0]               wr_data_q, wr_data_d;
  logic                              done_q, done_d;

  // Counts above the table depth clamp to the depth so addresses never wrap.
  function automatic logic [ROW_W-1:0] sat_rows(input logic [ROW_W-1:0] n);
    return (n > MAX_ROWS) ? MAX_ROWS : n;
  endfunction

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    row_d     = row_q;
    slot_d    = slot_q;
    acc_d     = acc_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          n_d    = sat_rows(row_count_i);
          row_d  = '0;
          slot_d = '0;
          acc_d  = '0;
          err_d  = 1'b0;
          if (sat_rows(row_count_i) == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (s_valid_i) begin
          acc_d[slot_q*SLOT_WIDTH +: SLOT_WIDTH] = s_data_i;
          if (s_last_i || (slot_q == LAST_SLOT)) begin
            // The write registers load here so the strobe lands one cycle later.
            state_d   = WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = row_q[VARIABLE_ADDRESS_WIDTH-1:0];
            wr_data_d = acc_d;
            if (!s_last_i) err_d = 1'b1;
          end else begin
            slot_d = slot_q + SLOT_IDX_W'(1);
          end
        end
      end
      WRITE: begin
        row_d  = row_q + ROW_W'(1);
        slot_d = '0;
        acc_d  = '0;
        if (row_q == n_q - ROW_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = FILL;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      n_q       <= '0;
      row_q     <= '0;
      slot_q    <= '0;
      acc_q     <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      row_q     <= row_d;
      slot_q    <= slot_d;
      acc_q     <= acc_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign s_ready_o        = (state_q == FILL);
  assign busy_o           = (state_q == FILL) || (state_q == WRITE);
  assign axi_wr_en_o      = wr_en_q;
  assign axi_wr_addr_o    = wr_addr_q;
  assign axi_wr_clauses_o = wr_data_q;
  assign done_o           = done_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_clause_table_loader.sv
// Directed-vector bench for clause_table_loader with hand-computed expected rows.
module tb_clause_table_loader;

  localparam int VAW = 11;
  localparam int SW  = 24;
  localparam int CW  = 480;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  logic           start_i = 1'b0;
  logic [VAW:0]   row_count_i = '0;
  logic           s_valid_i = 1'b0;
  logic           s_ready_o;
  logic [SW-1:0]  s_data_i = '0;
  logic           s_last_i = 1'b0;
  logic           axi_wr_en_o;
  logic [VAW-1:0] axi_wr_addr_o;
  logic [CW-1:0]  axi_wr_clauses_o;
  logic           busy_o, done_o, err_o;

  int n_vec = 0;
  int n_miss = 0;
  int wr_count = 0;
  int wc0;
  logic [CW-1:0] exp_row;

  clause_table_loader dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .row_count_i(row_count_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .s_last_i(s_last_i), .axi_wr_en_o(axi_wr_en_o), .axi_wr_addr_o(axi_wr_addr_o),
    .axi_wr_clauses_o(axi_wr_clauses_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (axi_wr_en_o) wr_count++;

  task automatic check_vec(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the beat is accepted.
  task automatic send_beat(input logic [SW-1:0] d, input logic l, input int gap);
    int guard;
    s_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = l;
    guard = 0;
    while (!s_ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check_vec("ready_timeout", 0, 1);
    @(negedge clk);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic do_start(input logic [VAW:0] n);
    start_i     = 1'b1;
    row_count_i = n;
    @(negedge clk);
    start_i     = 1'b0;
    row_count_i = '1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gaps [5] = '{2, 0, 3, 1, 2};
    repeat (3) @(negedge clk);
    check_vec("rst_wr_en", axi_wr_en_o, 0);
    check_vec("rst_addr", axi_wr_addr_o, 0);
    check_vec("rst_data", axi_wr_clauses_o, 0);
    check_vec("rst_busy", busy_o, 0);
    check_vec("rst_done", done_o, 0);
    check_vec("rst_err", err_o, 0);
    check_vec("rst_ready", s_ready_o, 0);
    rst_ni = 1'b1;
    @(negedge clk);

    // Two-row load
    do_start(2);
    check_vec("fill_busy", busy_o, 1);
    check_vec("fill_ready", s_ready_o, 1);
    send_beat(24'h000001, 0, 0);
    send_beat(24'h000002, 0, 0);
    check_vec("no_early_wr", axi_wr_en_o, 0);
    send_beat(24'h000003, 1, 0);
    check_vec("r0_wr_en", axi_wr_en_o, 1);
    check_vec("r0_addr", axi_wr_addr_o, 0);
    check_vec("r0_data", axi_wr_clauses_o, 480'h000003_000002_000001);
    check_vec("write_ready", s_ready_o, 0);
    @(negedge clk);
    check_vec("r0_wr_drop", axi_wr_en_o, 0);
    check_vec("r0_data_hold", axi_wr_clauses_o, 480'h000003_000002_000001);
    send_beat(24'hABCDEF, 1, 0);
    check_vec("r1_addr", axi_wr_addr_o, 1);
    check_vec("r1_data", axi_wr_clauses_o, 480'hABCDEF);
    @(negedge clk);
    check_vec("two_done", done_o, 1);
    check_vec("two_busy", busy_o, 0);
    check_vec("two_err", err_o, 0);
    @(negedge clk);
    check_vec("two_done_pulse", done_o, 0);
    check_vec("two_wr_count", wr_count, 2);

    // Zero rows
    do_start(0);
    check_vec("n0_done", done_o, 1);
    check_vec("n0_wr_en", axi_wr_en_o, 0);
    @(negedge clk);
    check_vec("n0_done_pulse", done_o, 0);
    check_vec("n0_wr_count", wr_count, 2);
    check_vec("n0_addr_hold", axi_wr_addr_o, 1);

    // Full row without s_last_i
    do_start(1);
    exp_row = '0;
    for (int i = 0; i < 20; i++) begin
      send_beat(24'(i + 1) * 24'h010101, 0, 0);
      exp_row[i*SW +: SW] = 24'(i + 1) * 24'h010101;
    end
    check_vec("full_wr_en", axi_wr_en_o, 1);
    check_vec("full_addr", axi_wr_addr_o, 0);
    check_vec("full_data", axi_wr_clauses_o, exp_row);
    check_vec("full_err", err_o, 1);
    @(negedge clk);
    check_vec("full_done", done_o, 1);
    @(negedge clk);
    check_vec("err_sticky", err_o, 1);

    // New start clears err; start while busy is ignored; stalls do not change the row
    do_start(1);
    check_vec("err_clear", err_o, 0);
    start_i     = 1'b1;
    row_count_i = '0;
    @(negedge clk);
    start_i = 1'b0;
    check_vec("start_ignored_busy", busy_o, 1);
    check_vec("start_ignored_done", done_o, 0);
    for (int k = 0; k < 5; k++)
      send_beat(24'h00C0D0 + 24'(k), (k == 4), gaps[k]);
    check_vec("stall_wr_en", axi_wr_en_o, 1);
    check_vec("stall_ready", s_ready_o, 0);
    check_vec("stall_data", axi_wr_clauses_o,
              480'h00C0D4_00C0D3_00C0D2_00C0D1_00C0D0);
    @(negedge clk);
    check_vec("stall_done", done_o, 1);
    @(negedge clk);

    // Reset on the closing beat
    do_start(2);
    send_beat(24'h111111, 0, 0);
    wc0 = wr_count;
    s_valid_i = 1'b1;
    s_data_i  = 24'h222222;
    s_last_i  = 1'b1;
    rst_ni    = 1'b0;
    @(negedge clk);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    check_vec("abort_wr_en", axi_wr_en_o, 0);
    check_vec("abort_data", axi_wr_clauses_o, 0);
    check_vec("abort_addr", axi_wr_addr_o, 0);
    check_vec("abort_busy", busy_o, 0);
    check_vec("abort_ready", s_ready_o, 0);
    rst_ni = 1'b1;
    @(negedge clk);
    check_vec("abort_no_write", wr_count - wc0, 0);

    // Load after reset behaves as from power-up
    do_start(1);
    send_beat(24'h777777, 1, 0);
    check_vec("post_rst_addr", axi_wr_addr_o, 0);
    check_vec("post_rst_data", axi_wr_clauses_o, 480'h777777);
    @(negedge clk);
    check_vec("post_rst_done", done_o, 1);
    @(negedge clk);

    // Saturated count: 4095 -> 2048 rows
    wc0 = wr_count;
    do_start(12'd4095);
    for (int r = 0; r < 2048; r++) begin
      send_beat(24'(r + 1), 1, 0);
      if (r == 2047) begin
        check_vec("sat_last_addr", axi_wr_addr_o, 2047);
        check_vec("sat_last_data", axi_wr_clauses_o, 480'h000800);
      end
      @(negedge clk);
    end
    check_vec("sat_done", done_o, 1);
    check_vec("sat_ready", s_ready_o, 0);
    @(negedge clk);
    check_vec("sat_wr_count", wr_count - wc0, 2048);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/clause_table_loader.md
CLAUSE_TABLE_LOADER -- requirements
Module: clause_table_loader

Interface
REQ-001 The block SHALL have parameter CLAUSE_COUNT, default 20, giving the number of literal-pair slots packed into one clause-table row.
REQ-002 The block SHALL have parameter VARIABLE_ADDRESS_WIDTH, default 11, giving the row address width (table depth 2^VARIABLE_ADDRESS_WIDTH).
REQ-003 The block SHALL have parameter NSAT, default 3, giving literals per clause.
REQ-004 The block SHALL derive localparam SLOT_WIDTH = (VARIABLE_ADDRESS_WIDTH+1)*(NSAT-1), default 24, and CT_WIDTH = SLOT_WIDTH*CLAUSE_COUNT, default 480.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-006 The block SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port start_i, input, 1 bit: pulse that begins a load; it is ignored unless the FSM is in IDLE.
REQ-008 The block SHALL have port row_count_i, input, VARIABLE_ADDRESS_WIDTH+1 bits: number of rows to load, sampled on an accepted start_i.
REQ-009 The block SHALL have port s_valid_i, input, 1 bit: the upstream slot word is valid.
REQ-010 The block SHALL have port s_ready_o, output, 1 bit: the block accepts a slot word this cycle.
REQ-011 The block SHALL have port s_data_i, input, SLOT_WIDTH bits: the addresses and negation bits of the other literals in one clause.
REQ-012 The block SHALL have port s_last_i, input, 1 bit: this word is the final slot of the current row.
REQ-013 The block SHALL have port axi_wr_en_o, output, 1 bit: write strobe to the clause table.
REQ-014 The block SHALL have port axi_wr_addr_o, output, VARIABLE_ADDRESS_WIDTH bits: clause-table row address.
REQ-015 The block SHALL have port axi_wr_clauses_o, output, CT_WIDTH bits: the packed row.
REQ-016 The block SHALL have port busy_o, output, 1 bit: asserted in FILL and WRITE.
REQ-017 The block SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-018 The block SHALL have port err_o, output, 1 bit: sticky malformed-row flag.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, FILL, WRITE, DONE.
REQ-020 In IDLE, start_i=1 with a sampled row count N>0 SHALL move the FSM to FILL with row=0, slot=0, the accumulator zeroed and err_o cleared; if N=0 the FSM SHALL go to DONE instead.
REQ-021 A sampled row_count_i greater than 2^VARIABLE_ADDRESS_WIDTH SHALL saturate to 2^VARIABLE_ADDRESS_WIDTH.
REQ-022 s_ready_o SHALL be 1 only in FILL; a beat is accepted only when s_valid_i=1 and s_ready_o=1 in the same cycle.
REQ-023 An accepted beat SHALL be written into accumulator bits [slot*SLOT_WIDTH +: SLOT_WIDTH], and slot SHALL then increment; slot 0 occupies the LSBs.
REQ-024 A row SHALL close, and the FSM SHALL move to WRITE, on the accepted beat that has s_last_i=1 or that fills slot CLAUSE_COUNT-1; unwritten slots SHALL remain zero.
REQ-025 If a row closes on slot CLAUSE_COUNT-1 with s_last_i=0, err_o SHALL be set and SHALL hold until the next accepted start_i or until reset.
REQ-026 WRITE SHALL last exactly one cycle, with axi_wr_en_o=1, axi_wr_addr_o=row and axi_wr_clauses_o=accumulator, all driven from registers.
REQ-027 The write strobe SHALL be asserted in the cycle after the closing beat is accepted, so the latency from closing beat to write is 1 cycle.
REQ-028 When WRITE exits, the block SHALL increment row, clear slot and the accumulator, and go to DONE if the written row was N-1, else to FILL.
REQ-029 Outside WRITE, axi_wr_en_o SHALL be 0, and axi_wr_addr_o and axi_wr_clauses_o SHALL hold their last values.
REQ-030 DONE SHALL assert done_o for exactly one cycle and then return to IDLE.
REQ-031 Upstream stalls (s_valid_i=0) in FILL SHALL hold all state; there is no timeout.
REQ-032 start_i in any state other than IDLE SHALL have no effect.
REQ-033 A row address SHALL never wrap; the maximum address written is N-1 ≤ 2^VARIABLE_ADDRESS_WIDTH-1.

Reset
REQ-034 rst_ni=0 at a rising edge SHALL force IDLE; zero row, slot and the accumulator; and drive every output to 0, including axi_wr_addr_o and axi_wr_clauses_o.
REQ-035 Reset asserted in FILL or WRITE SHALL abort the load immediately, with no write strobe in the following cycle.
REQ-036 The first start_i after reset is released SHALL behave exactly as from power-up.

Verification
REQ-037 Scenario: start with N=2; row 0 sends 3 beats 0x000001, 0x000002, 0x000003 (last on the third); row 1 sends 1 beat 0xABCDEF with last. Required: writes to addr 0 with slots 0..2 = 1, 2, 3 and the rest 0, and to addr 1 with slot 0 = 0xABCDEF; then a done_o pulse; err_o=0.
REQ-038 Scenario: 20 beats with no s_last_i. Required: a write on the cycle after beat 20, with the full 480-bit row; err_o=1 and sticky until the next start.
REQ-039 Scenario: start with N=0. Required: done_o asserted 1 cycle after start, with no axi_wr_en_o.
REQ-040 Scenario: s_valid_i toggled randomly during a row. Required: the packed row is identical to the stall-free case, and s_ready_o=0 during WRITE.
REQ-041 Scenario: rst_ni=0 on the cycle a closing beat is accepted. Required: no write strobe follows, all outputs are 0, and the FSM is in IDLE.
REQ-042 Scenario: row_count_i=4095 with VARIABLE_ADDRESS_WIDTH=11. Required: the count saturates to 2048, the final write is at addr 2047, and done_o is asserted afterwards.
